// File: rtl/mips_mc_controller_if.sv
// Control bus between the multicycle MIPS controller and its datapath.
// The controller (master) receives the decoded instruction fields and the ALU
// zero flag and drives every datapath enable/select plus its state for debug.
interface mips_mc_controller_if;
  logic [5:0] opc;
  logic [5:0] func;
  logic       zero;
  logic       PCWrite;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUop;
  logic [1:0] PCSrc;
  logic [1:0] RegDst;
  logic [1:0] RegData;
  logic [3:0] state;

  modport master (
    input  opc, func, zero,
    output PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite,
           ALUSrcA, ALUSrcB, ALUop, PCSrc, RegDst, RegData, state
  );

  modport slave (
    output opc, func, zero,
    input  PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite,
           ALUSrcA, ALUSrcB, ALUop, PCSrc, RegDst, RegData, state
  );
endinterface

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control FSM. Outputs are Moore-decoded from the current
// state (plus the instruction fields held in the IR, and zero in BR).
// While rst is high every output is forced to 0, so no enable can fire
// during reset; once rst drops, the IF decode is visible before the next edge.
module mips_mc_controller (
  input  logic                      clk,
  input  logic                      rst,
  mips_mc_controller_if.master      bus
);

  typedef enum logic [3:0] {
    S_IF    = 4'd0,
    S_ID    = 4'd1,
    S_MADDR = 4'd2,
    S_MRD   = 4'd3,
    S_LWB   = 4'd4,
    S_MWR   = 4'd5,
    S_REX   = 4'd6,
    S_RWB   = 4'd7,
    S_IEX   = 4'd8,
    S_IWB   = 4'd9,
    S_BR    = 4'd10,
    S_J     = 4'd11,
    S_JAL   = 4'd12,
    S_JR    = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  // R-type with func=jr is handled by its own state rather than REX/RWB.
  function automatic logic is_jr(input logic [5:0] opc, input logic [5:0] func);
    is_jr = (opc == OP_RTYPE) && (func == FN_JR);
  endfunction

  // Branch taken condition: beq takes on zero, bne on not-zero.
  function automatic logic branch_taken(input logic [5:0] opc, input logic zero);
    branch_taken = (opc == OP_BNE) ? ~zero : zero;
  endfunction

  state_t     state_r;
  state_t     state_next_s;
  logic       pc_write_s;
  logic       iord_s;
  logic       mem_read_s;
  logic       mem_write_s;
  logic       ir_write_s;
  logic       reg_write_s;
  logic       alu_src_a_s;
  logic [1:0] alu_src_b_s;
  logic [1:0] alu_op_s;
  logic [1:0] pc_src_s;
  logic [1:0] reg_dst_s;
  logic [1:0] reg_data_s;

  // State register; asynchronous reset abandons any instruction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IF;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and Moore output decode; everything defaults to 0 / IF.
  always_comb begin
    state_next_s = S_IF;
    pc_write_s   = 1'b0;
    iord_s       = 1'b0;
    mem_read_s   = 1'b0;
    mem_write_s  = 1'b0;
    ir_write_s   = 1'b0;
    reg_write_s  = 1'b0;
    alu_src_a_s  = 1'b0;
    alu_src_b_s  = 2'b00;
    alu_op_s     = 2'b00;
    pc_src_s     = 2'b00;
    reg_dst_s    = 2'b00;
    reg_data_s   = 2'b00;
    if (rst) begin
      state_next_s = S_IF;
    end else begin
      case (state_r)
        S_IF: begin
          mem_read_s   = 1'b1;
          ir_write_s   = 1'b1;
          alu_src_b_s  = 2'b01;
          pc_write_s   = 1'b1;
          state_next_s = S_ID;
        end
        S_ID: begin
          // Branch target is precomputed here into ALUOut.
          alu_src_b_s = 2'b11;
          case (bus.opc)
            OP_LW, OP_SW:     state_next_s = S_MADDR;
            OP_RTYPE:         state_next_s = is_jr(bus.opc, bus.func) ? S_JR : S_REX;
            OP_ADDI, OP_SLTI: state_next_s = S_IEX;
            OP_BEQ, OP_BNE:   state_next_s = S_BR;
            OP_J:             state_next_s = S_J;
            OP_JAL:           state_next_s = S_JAL;
            // Undefined opcode: PC already advanced, so it retires as a NOP.
            default:          state_next_s = S_IF;
          endcase
        end
        S_MADDR: begin
          alu_src_a_s  = 1'b1;
          alu_src_b_s  = 2'b10;
          state_next_s = (bus.opc == OP_SW) ? S_MWR : S_MRD;
        end
        S_MRD: begin
          mem_read_s   = 1'b1;
          iord_s       = 1'b1;
          state_next_s = S_LWB;
        end
        S_LWB: begin
          reg_write_s  = 1'b1;
          reg_data_s   = 2'b01;
          state_next_s = S_IF;
        end
        S_MWR: begin
          mem_write_s  = 1'b1;
          iord_s       = 1'b1;
          state_next_s = S_IF;
        end
        S_REX: begin
          alu_src_a_s  = 1'b1;
          alu_op_s     = 2'b10;
          state_next_s = S_RWB;
        end
        S_RWB: begin
          reg_write_s  = 1'b1;
          reg_dst_s    = 2'b01;
          state_next_s = S_IF;
        end
        S_IEX: begin
          alu_src_a_s  = 1'b1;
          alu_src_b_s  = 2'b10;
          alu_op_s     = (bus.opc == OP_SLTI) ? 2'b11 : 2'b00;
          state_next_s = S_IWB;
        end
        S_IWB: begin
          reg_write_s  = 1'b1;
          state_next_s = S_IF;
        end
        S_BR: begin
          alu_src_a_s  = 1'b1;
          alu_op_s     = 2'b01;
          pc_src_s     = 2'b01;
          pc_write_s   = branch_taken(bus.opc, bus.zero);
          state_next_s = S_IF;
        end
        S_J: begin
          pc_src_s     = 2'b10;
          pc_write_s   = 1'b1;
          state_next_s = S_IF;
        end
        S_JAL: begin
          // $31 is written with the current PC, which already holds PC+4.
          pc_src_s     = 2'b10;
          pc_write_s   = 1'b1;
          reg_write_s  = 1'b1;
          reg_dst_s    = 2'b10;
          reg_data_s   = 2'b10;
          state_next_s = S_IF;
        end
        S_JR: begin
          alu_src_a_s  = 1'b1;
          pc_src_s     = 2'b11;
          pc_write_s   = 1'b1;
          state_next_s = S_IF;
        end
        // Encodings 14-15 recover to IF with every enable low.
        default: begin
          state_next_s = S_IF;
        end
      endcase
    end
  end

  assign bus.PCWrite  = pc_write_s;
  assign bus.IorD     = iord_s;
  assign bus.MemRead  = mem_read_s;
  assign bus.MemWrite = mem_write_s;
  assign bus.IRWrite  = ir_write_s;
  assign bus.RegWrite = reg_write_s;
  assign bus.ALUSrcA  = alu_src_a_s;
  assign bus.ALUSrcB  = alu_src_b_s;
  assign bus.ALUop    = alu_op_s;
  assign bus.PCSrc    = pc_src_s;
  assign bus.RegDst   = reg_dst_s;
  assign bus.RegData  = reg_data_s;
  assign bus.state    = state_r;

endmodule
